// File: rtl/pulse_capture_module_if.sv
// Pulse capture bus: sampled pulse input, clear, and the published measurement results.
// Duty_Err exists only when PULSE_CAPTURE_DUTY_EN is defined.
interface pulse_capture_module_if #(
   parameter int unsigned CNT_W = 21
);
   logic             Pulse_In;
   logic             Clear;
   logic [CNT_W-1:0] High_Time;
   logic [CNT_W-1:0] Period;
   logic             Done;
   logic             Valid;
   logic             Timeout;
`ifdef PULSE_CAPTURE_DUTY_EN
   logic             Duty_Err;

   modport master (
      output Pulse_In, Clear,
      input  High_Time, Period, Done, Valid, Timeout, Duty_Err
   );
   modport slave (
      input  Pulse_In, Clear,
      output High_Time, Period, Done, Valid, Timeout, Duty_Err
   );
`else
   modport master (
      output Pulse_In, Clear,
      input  High_Time, Period, Done, Valid, Timeout
   );
   modport slave (
      input  Pulse_In, Clear,
      output High_Time, Period, Done, Valid, Timeout
   );
`endif
endinterface

// File: rtl/pulse_capture_module.sv
// Measures high time and rise-to-rise period of a free-running pulse, with no-edge timeout.
// Define PULSE_CAPTURE_DUTY_EN to add the Duty_Err high-time window check.
module pulse_capture_module #(
   parameter int unsigned CNT_W   = 21,
   parameter int unsigned TIMEOUT = 2_097_151,
   parameter int unsigned HI_MIN  = 500_000,
   parameter int unsigned HI_MAX  = 500_000
) (
   input  logic                  CLK,
   input  logic                  RST,
   pulse_capture_module_if.slave bus
);

   if (TIMEOUT < 2 || 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_timeout
      $error("TIMEOUT must lie in [2, 2**CNT_W)");
   end
   if (HI_MIN > HI_MAX) begin : g_bad_window
      $error("HI_MIN must not exceed HI_MAX");
   end

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] HIGH = 2'd1;
   localparam logic [1:0] LOW  = 2'd2;

   localparam logic [CNT_W-1:0] TO_C    = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             sync1_q, s_q, s_d_q;
   logic             rise, fall;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_q, hi_d;
   logic [CNT_W-1:0] high_time_q, high_time_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;
   logic             timeout_q, timeout_d;
`ifdef PULSE_CAPTURE_DUTY_EN
   localparam logic [CNT_W-1:0] HI_MIN_C = CNT_W'(HI_MIN);
   localparam logic [CNT_W-1:0] HI_MAX_C = CNT_W'(HI_MAX);
   logic             duty_q, duty_d;
`endif

   // Synchroniser plus edge-detect flop; Clear leaves these running so a rise right after it counts.
   always_ff @(posedge CLK) begin
      if (RST) begin
         sync1_q <= 1'b0;
         s_q     <= 1'b0;
         s_d_q   <= 1'b0;
      end else begin
         sync1_q <= bus.Pulse_In;
         s_q     <= sync1_q;
         s_d_q   <= s_q;
      end
   end

   assign rise = s_q & ~s_d_q;
   assign fall = ~s_q & s_d_q;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      hi_d        = hi_q;
      high_time_d = high_time_q;
      period_d    = period_q;
      done_d      = 1'b0;
      valid_d     = valid_q;
      timeout_d   = timeout_q;
`ifdef PULSE_CAPTURE_DUTY_EN
      duty_d      = duty_q;
`endif
      if (bus.Clear) begin
         state_d     = IDLE;
         cnt_d       = '0;
         hi_d        = '0;
         high_time_d = '0;
         period_d    = '0;
         valid_d     = 1'b0;
         timeout_d   = 1'b0;
`ifdef PULSE_CAPTURE_DUTY_EN
         duty_d      = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               cnt_d = '0;
               if (rise) begin
                  state_d = HIGH;
                  cnt_d   = CNT_ONE;
               end
            end
            HIGH, LOW: begin
               cnt_d = (cnt_q == TO_C) ? cnt_q : cnt_q + 1'b1;
               // A rise always wins over a coincident timeout.
               if (rise) begin
                  state_d = HIGH;
                  cnt_d   = CNT_ONE;
                  if (state_q == LOW) begin
                     period_d    = cnt_q;
                     high_time_d = hi_q;
                     done_d      = 1'b1;
                     valid_d     = 1'b1;
`ifdef PULSE_CAPTURE_DUTY_EN
                     duty_d      = (hi_q < HI_MIN_C) | (hi_q > HI_MAX_C);
`endif
                  end
               end else if (fall && state_q == HIGH) begin
                  state_d = LOW;
                  hi_d    = cnt_q;
               end else if (cnt_q == TO_C && !fall) begin
                  state_d   = IDLE;
                  cnt_d     = '0;
                  timeout_d = 1'b1;
                  valid_d   = 1'b0;
`ifdef PULSE_CAPTURE_DUTY_EN
                  duty_d    = 1'b0;
`endif
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         hi_q        <= '0;
         high_time_q <= '0;
         period_q    <= '0;
         done_q      <= 1'b0;
         valid_q     <= 1'b0;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hi_q        <= hi_d;
         high_time_q <= high_time_d;
         period_q    <= period_d;
         done_q      <= done_d;
         valid_q     <= valid_d;
         timeout_q   <= timeout_d;
      end
   end

`ifdef PULSE_CAPTURE_DUTY_EN
   always_ff @(posedge CLK) begin
      if (RST) duty_q <= 1'b0;
      else     duty_q <= duty_d;
   end
   assign bus.Duty_Err = duty_q;
`endif

   assign bus.High_Time = high_time_q;
   assign bus.Period    = period_q;
   assign bus.Done      = done_q;
   assign bus.Valid     = valid_q;
   assign bus.Timeout   = timeout_q;

endmodule

// File: tb/tb_pulse_capture_module.sv
// Directed bench for pulse_capture_module: pulse-shape table plus timeout/Clear/RST sequences.
// Every Done strobe is checked against a queue of expected results pushed as pulses are closed.
module tb_pulse_capture_module;

   localparam int unsigned CNT_W   = 12;
   localparam int unsigned TIMEOUT = 4000;
   localparam int unsigned HI_MIN  = 4;
   localparam int unsigned HI_MAX  = 6;

   logic clk = 1'b0;
   logic rst;

   pulse_capture_module_if #(.CNT_W(CNT_W)) bus ();

   pulse_capture_module #(
      .CNT_W  (CNT_W),
      .TIMEOUT(TIMEOUT),
      .HI_MIN (HI_MIN),
      .HI_MAX (HI_MAX)
   ) dut (
      .CLK(clk),
      .RST(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int hi;
      int per;
      bit duty;
   } exp_t;

   typedef struct {
      bit clr;
      int hi;
      int lo;
      int n;
      int tail;
      int exp_hi;
      int exp_per;
      bit exp_duty;
      int exp_dones;
   } row_t;

   exp_t sb[$];
   exp_t prev;
   bit   armed;
   int   checks;
   int   errors;
   int   done_count;
   bit   done_prev;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Driving a rise closes the previous pulse, whose result Done must then report.
   task automatic drive_pulse(input int hi, input int lo, input exp_t e);
      if (armed) sb.push_back(prev);
      prev  = e;
      armed = 1'b1;
      bus.Pulse_In = 1'b1;
      repeat (hi) tick();
      bus.Pulse_In = 1'b0;
      repeat (lo) tick();
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_high_time"}, int'(bus.High_Time), 0);
      chk({tag, "_period"},    int'(bus.Period), 0);
      chk({tag, "_done"},      int'(bus.Done), 0);
      chk({tag, "_valid"},     int'(bus.Valid), 0);
      chk({tag, "_timeout"},   int'(bus.Timeout), 0);
`ifdef PULSE_CAPTURE_DUTY_EN
      chk({tag, "_duty_err"},  int'(bus.Duty_Err), 0);
`endif
   endtask

   task automatic do_clear();
      bus.Clear = 1'b1;
      tick();
      bus.Clear = 1'b0;
      armed = 1'b0;
      chk_zero("clear");
   endtask

   always @(negedge clk) begin
      if (!rst && bus.Done) begin
         exp_t e;
         done_count++;
         chk("done_one_cycle", int'(done_prev), 0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sb.pop_front();
            chk("done_high_time", int'(bus.High_Time), e.hi);
            chk("done_period",    int'(bus.Period), e.per);
            chk("done_valid",     int'(bus.Valid), 1);
`ifdef PULSE_CAPTURE_DUTY_EN
            chk("done_duty_err",  int'(bus.Duty_Err), int'(e.duty));
`endif
         end
      end
      done_prev = bus.Done;
   end

   initial begin
      row_t rows[6];
      exp_t e5;
      int   d0;

      // clr, hi, lo, n, tail, exp_hi, exp_per, exp_duty, exp_dones
      rows[0] = '{1'b1, 5, 15, 4, 0, 5, 20, 1'b0, 3};
      rows[1] = '{1'b0, 9, 11, 2, 0, 9, 20, 1'b1, 2};
      rows[2] = '{1'b1, 4, 4,  3, 0, 4, 8,  1'b0, 2};
      rows[3] = '{1'b1, 7, 3,  3, 0, 7, 10, 1'b1, 2};
      rows[4] = '{1'b1, 6, 2,  3, 0, 6, 8,  1'b0, 2};
      rows[5] = '{1'b1, 1, 1,  6, 4, 1, 2,  1'b1, 5};
      e5 = '{5, 20, 1'b0};

      checks = 0;
      errors = 0;
      done_count = 0;
      done_prev = 1'b0;
      armed = 1'b0;
      rst = 1'b1;
      bus.Pulse_In = 1'b0;
      bus.Clear = 1'b0;
      repeat (3) tick();
      chk_zero("reset");
      rst = 1'b0;
      tick();

      foreach (rows[i]) begin
         exp_t e;
         e = '{rows[i].exp_hi, rows[i].exp_per, rows[i].exp_duty};
         d0 = done_count;
         if (rows[i].clr) do_clear();
         for (int k = 0; k < rows[i].n; k++) drive_pulse(rows[i].hi, rows[i].lo, e);
         repeat (rows[i].tail) tick();
         chk($sformatf("row%0d_dones", i),     done_count - d0, rows[i].exp_dones);
         chk($sformatf("row%0d_high_time", i), int'(bus.High_Time), rows[i].exp_hi);
         chk($sformatf("row%0d_period", i),    int'(bus.Period), rows[i].exp_per);
         chk($sformatf("row%0d_valid", i),     int'(bus.Valid), 1);
`ifdef PULSE_CAPTURE_DUTY_EN
         chk($sformatf("row%0d_duty_err", i),  int'(bus.Duty_Err), int'(rows[i].exp_duty));
`endif
      end

      // Stuck high: rise seen after edge 2, Cnt=1 after edge 3, Cnt=4000 after edge 4002,
      // so the flag shows after edge 4003.
      do_clear();
      drive_pulse(5, 15, e5);
      drive_pulse(5, 15, e5);
      d0 = done_count;
      if (armed) sb.push_back(prev);
      armed = 1'b0;
      bus.Pulse_In = 1'b1;
      repeat (4002) tick();
      chk("to_before_flag",  int'(bus.Timeout), 0);
      chk("to_before_valid", int'(bus.Valid), 1);
      tick();
      chk("to_flag",         int'(bus.Timeout), 1);
      chk("to_valid",        int'(bus.Valid), 0);
      chk("to_hold_high",    int'(bus.High_Time), 5);
      chk("to_hold_period",  int'(bus.Period), 20);
      chk("to_dones",        done_count - d0, 1);
      bus.Pulse_In = 1'b0;
      repeat (6) tick();
      drive_pulse(5, 15, e5);
      chk("rearm_timeout",   int'(bus.Timeout), 1);
      chk("rearm_valid",     int'(bus.Valid), 0);
      drive_pulse(5, 15, e5);
      chk("rearm_result_valid",   int'(bus.Valid), 1);
      chk("rearm_result_timeout", int'(bus.Timeout), 1);

      // Clear lands on the cycle the rise is detected; that rise must be ignored.
      d0 = done_count;
      bus.Pulse_In = 1'b1;
      tick();
      tick();
      do_clear();
      repeat (4) tick();
      bus.Pulse_In = 1'b0;
      repeat (15) tick();
      drive_pulse(5, 15, e5);
      chk("clr_rise_first_arm", done_count - d0, 0);
      drive_pulse(5, 15, e5);
      chk("clr_rise_dones", done_count - d0, 1);

      // RST in the middle of a low phase discards the partial measurement.
      do_clear();
      drive_pulse(5, 15, e5);
      drive_pulse(5, 15, e5);
      if (armed) sb.push_back(prev);
      bus.Pulse_In = 1'b1;
      repeat (5) tick();
      bus.Pulse_In = 1'b0;
      repeat (6) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      armed = 1'b0;
      chk_zero("rst_mid");
      repeat (9) tick();
      d0 = done_count;
      drive_pulse(5, 15, e5);
      chk("rst_first_arm", done_count - d0, 0);
      drive_pulse(5, 15, e5);
      chk("rst_dones", done_count - d0, 1);

      // IDLE never times out.
      do_clear();
      repeat (4100) tick();
      chk("idle_no_timeout", int'(bus.Timeout), 0);

      repeat (5) tick();
      chk("pending_results", sb.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
